// File: rtl/mult_pkg.sv
// Shared constants and FSM state type for the multiplier arbiter slice.
package mult_pkg;

    localparam int MULT_OPW   = 8;
    localparam int MULT_PRODW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } mult_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after ptr (mod NREQ), as one-hot grant and encoded index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [IDW:0]   sum  [NREQ];
    logic [IDW:0]   diff [NREQ];
    logic [IDW-1:0] pos  [NREQ];
    logic [NREQ-1:0] hit;
    logic [IDW-1:0] sel  [NREQ+1];
    logic [NREQ:0]  found;

    assign sel[NREQ]   = '0;
    assign found[NREQ] = 1'b0;

    // Offset gi from the pointer maps to requester pos[gi]; lower offsets take priority.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_scan
        assign sum[gi]   = {1'b0, ptr} + (IDW+1)'(gi);
        assign diff[gi]  = sum[gi] - NREQ_W;
        assign pos[gi]   = (sum[gi] >= NREQ_W) ? diff[gi][IDW-1:0] : sum[gi][IDW-1:0];
        assign hit[gi]   = req[pos[gi]];
        assign sel[gi]   = hit[gi] ? pos[gi] : sel[gi+1];
        assign found[gi] = hit[gi] | found[gi+1];
    end

    assign idx = sel[0];
    assign any = found[0];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
        assign grant[gi] = any && (idx == IDW'(gi));
    end

endmodule

// File: rtl/wallace_tree.sv
// Combinational unsigned 8x8 multiplier: partial products reduced by carry-save layers, then one final add.
module wallace_tree
    import mult_pkg::*;
(
    input  logic [MULT_OPW-1:0]   a,
    input  logic [MULT_OPW-1:0]   b,
    output logic [MULT_PRODW-1:0] product
);

    function automatic logic [MULT_PRODW-1:0] csa_sum(
        input logic [MULT_PRODW-1:0] x,
        input logic [MULT_PRODW-1:0] y,
        input logic [MULT_PRODW-1:0] z
    );
        return x ^ y ^ z;
    endfunction

    function automatic logic [MULT_PRODW-1:0] csa_carry(
        input logic [MULT_PRODW-1:0] x,
        input logic [MULT_PRODW-1:0] y,
        input logic [MULT_PRODW-1:0] z
    );
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    logic [MULT_PRODW-1:0] pp [MULT_OPW];

    for (genvar gi = 0; gi < MULT_OPW; gi++) begin : g_pp
        assign pp[gi] = {{(MULT_PRODW-MULT_OPW){1'b0}}, a & {MULT_OPW{b[gi]}}} << gi;
    end

    // 8 rows -> 6 -> 4 -> 3 -> 2; the true product fits in 16 bits, so dropped carries are zero.
    logic [MULT_PRODW-1:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

    assign s0 = csa_sum(pp[0], pp[1], pp[2]);
    assign c0 = csa_carry(pp[0], pp[1], pp[2]);
    assign s1 = csa_sum(pp[3], pp[4], pp[5]);
    assign c1 = csa_carry(pp[3], pp[4], pp[5]);

    assign s2 = csa_sum(s0, c0, s1);
    assign c2 = csa_carry(s0, c0, s1);
    assign s3 = csa_sum(c1, pp[6], pp[7]);
    assign c3 = csa_carry(c1, pp[6], pp[7]);

    assign s4 = csa_sum(s2, c2, s3);
    assign c4 = csa_carry(s2, c2, s3);

    assign s5 = csa_sum(s4, c4, c3);
    assign c5 = csa_carry(s4, c4, c3);

    assign product = s5 + c5;

endmodule

// File: rtl/mult_arbiter.sv
// Shares one wallace_tree multiplier among NREQ valid/ready requesters, tagging each product with its requester ID.
// Define MULT_ARB_STATS_EN to add stat_ops (wrapping handshake count) and stat_stall (saturating stall count).
module mult_arbiter
    import mult_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*8-1:0]      req_a,
    input  logic [NREQ*8-1:0]      req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [MULT_PRODW-1:0]  rsp_product,
    output logic [IDW-1:0]         rsp_id
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [15:0]            stat_ops,
    output logic [15:0]            stat_stall
`endif
);

    mult_arb_state_t       state_reg;
    logic [IDW-1:0]        rr_ptr_reg;
    logic [MULT_OPW-1:0]   a_reg, b_reg;
    logic [IDW-1:0]        id_reg;
    logic [MULT_PRODW-1:0] product_reg;
    logic [IDW-1:0]        rsp_id_reg;
    logic                  rsp_valid_reg;

    logic [MULT_OPW-1:0]   a_arr [NREQ];
    logic [MULT_OPW-1:0]   b_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*MULT_OPW +: MULT_OPW];
        assign b_arr[gi] = req_b[gi*MULT_OPW +: MULT_OPW];
    end

    logic [NREQ-1:0] win_grant;
    logic [IDW-1:0]  win_idx;
    logic            win_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    logic [MULT_PRODW-1:0] mul_product;

    wallace_tree u_mul (
        .a       (a_reg),
        .b       (b_reg),
        .product (mul_product)
    );

    // Grant is only offered while idle, so acceptance and response handshake never share a cycle.
    assign req_ready   = (state_reg == IDLE) ? win_grant : '0;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_product = product_reg;
    assign rsp_id      = rsp_id_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            id_reg        <= '0;
            product_reg   <= '0;
            rsp_id_reg    <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_any) begin
                        a_reg      <= a_arr[win_idx];
                        b_reg      <= b_arr[win_idx];
                        id_reg     <= win_idx;
                        rr_ptr_reg <= (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;
                        state_reg  <= MUL;
                    end
                end
                MUL: begin
                    product_reg   <= mul_product;
                    rsp_id_reg    <= id_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

`ifdef MULT_ARB_STATS_EN
    logic [15:0] stat_ops_reg;
    logic [15:0] stat_stall_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_reg   <= '0;
            stat_stall_reg <= '0;
        end else begin
            if (rsp_valid_reg && rsp_ready) begin
                stat_ops_reg <= stat_ops_reg + 16'd1;
            end
            if (rsp_valid_reg && !rsp_ready && (stat_stall_reg != 16'hFFFF)) begin
                stat_stall_reg <= stat_stall_reg + 16'd1;
            end
        end
    end

    assign stat_ops   = stat_ops_reg;
    assign stat_stall = stat_stall_reg;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: spec-level model compared every cycle plus directed literal checks.
module tb_mult_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_product;
    logic [1:0]        rsp_id;
`ifdef MULT_ARB_STATS_EN
    logic [15:0]       stat_ops;
    logic [15:0]       stat_stall;
`endif

    mult_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id)
`ifdef MULT_ARB_STATS_EN
        ,
        .stat_ops    (stat_ops),
        .stat_stall  (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int winner(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Transaction-level model: busy while an operation is in flight, response appears two edges after accept.
    bit          m_busy;
    int          m_age, m_ptr, m_id, m_a, m_b, m_rid;
    bit          m_rsp_valid;
    logic [15:0] m_prod;

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            m_busy = 0; m_age = 0; m_ptr = 0; m_id = 0; m_a = 0; m_b = 0;
            m_rsp_valid = 0; m_prod = 16'h0; m_rid = 0;
        end else begin
            if (!m_busy) begin
                g = winner(req_valid, m_ptr);
                if (g >= 0) begin
                    m_a    = int'(req_a[g*8 +: 8]);
                    m_b    = int'(req_b[g*8 +: 8]);
                    m_id   = g;
                    m_ptr  = (g + 1) % NREQ;
                    m_busy = 1;
                    m_age  = 0;
                end
            end else if (m_age == 0) begin
                m_rsp_valid = 1;
                m_prod      = 16'(m_a * m_b);
                m_rid       = m_id;
                m_age       = 1;
            end else if (rsp_ready) begin
                m_rsp_valid = 0;
                m_busy      = 0;
            end
        end
    end

    always @(posedge clk) cyc++;

    int          g_ids[$];
    int          g_cyc[$];
    int          r_ids[$];
    logic [15:0] r_prod[$];

    always @(negedge clk) begin
        if (!rst) begin
            check("req_ready", 32'(req_ready), 32'(m_busy ? '0 : onehot(winner(req_valid, m_ptr))));
            check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
            check("rsp_product", 32'(rsp_product), 32'(m_prod));
            check("rsp_id", 32'(rsp_id), 32'(m_rid));
            if ((req_valid & req_ready) != '0) begin
                for (int k = 0; k < NREQ; k++)
                    if (req_ready[k]) begin g_ids.push_back(k); g_cyc.push_back(cyc); end
            end
            if (rsp_valid && rsp_ready) begin
                $display("txn id=%0d product=%h cycle=%0d", rsp_id, rsp_product, cyc);
                r_ids.push_back(int'(rsp_id));
                r_prod.push_back(rsp_product);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b);
        req_a[k*8 +: 8] = a;
        req_b[k*8 +: 8] = b;
        req_valid[k]    = 1'b1;
    endtask

    task automatic wait_ready(input int k, output bit ok);
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[k]) ok = 1;
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1;
        end
    endtask

    task automatic wait_count(input int want_g, input int want_r, output bit ok);
        ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            #1;
            if (g_ids.size() >= want_g && r_ids.size() >= want_r) ok = 1;
        end
    endtask

    // One complete operation with rsp_ready held high; returns just after the response handshake edge.
    task automatic do_op(input string name, input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
        bit ok;
        set_req(k, a, b);
        wait_ready(k, ok);
        check({name, "_grant"}, 32'(ok), 32'd1);
        tick();
        req_valid[k] = 1'b0;
        wait_rsp(ok);
        check({name, "_rsp"}, 32'(ok), 32'd1);
        check({name, "_product"}, 32'(rsp_product), 32'(exp));
        check({name, "_id"}, 32'(rsp_id), 32'(k));
        tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    logic [7:0]  fa [NREQ] = '{8'h03, 8'h10, 8'h7F, 8'hFF};
    logic [7:0]  fb [NREQ] = '{8'h05, 8'h10, 8'h02, 8'h11};
    logic [15:0] fp [NREQ] = '{16'h000F, 16'h0100, 16'h00FE, 16'h10EF};

    initial begin
        bit ok;
        int n;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_product", 32'(rsp_product), 32'h0);
        check("reset_rsp_id", 32'(rsp_id), 32'h0);

        // Single request from requester 2, held for two operations
        tick();
        set_req(2, 8'h0C, 8'h0A);
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'b0100);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 10);
        check("single_latency", 32'(n), 32'd2);
        check("single_product", 32'(rsp_product), 32'h0078);
        check("single_id", 32'(rsp_id), 32'd2);
        wait_count(2, 0, ok);
        check("single_second_grant", 32'(ok), 32'd1);
        tick();
        req_valid[2] = 1'b0;
        if (g_cyc.size() >= 2) check("single_spacing", 32'(g_cyc[1] - g_cyc[0]), 32'd3);
        wait_count(2, 2, ok);
        check("single_drain", 32'(ok), 32'd1);
        tick();

        // Corner operands
        do_op("ff_ff", 0, 8'hFF, 8'hFF, 16'hFE01);
        do_op("zero", 1, 8'h00, 8'hA5, 16'h0000);
        do_op("pow2", 3, 8'h80, 8'h02, 16'h0100);
        do_op("one", 0, 8'h01, 8'h37, 16'h0037);

        // Fairness: all requesters continuously valid from rr_ptr=0
        pulse_reset();
        g_ids.delete(); g_cyc.delete(); r_ids.delete(); r_prod.delete();
        for (int k = 0; k < NREQ; k++) set_req(k, fa[k], fb[k]);
        wait_count(5, 0, ok);
        check("fair_grants", 32'(ok), 32'd1);
        tick();
        req_valid = '0;
        wait_count(5, 5, ok);
        check("fair_drain", 32'(ok), 32'd1);
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("fair_order%0d", i), 32'(g_ids[i]), 32'(i % NREQ));
                check($sformatf("fair_rsp_id%0d", i), 32'(r_ids[i]), 32'(i % NREQ));
                check($sformatf("fair_rsp_prod%0d", i), 32'(r_prod[i]), 32'(fp[i % NREQ]));
                if (i > 0) check($sformatf("fair_spacing%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
            end
        end
        tick();

        // Backpressure for 5 cycles
        rsp_ready = 1'b0;
        set_req(1, 8'h21, 8'h03);
        wait_ready(1, ok);
        check("bp_grant", 32'(ok), 32'd1);
        tick();
        req_valid[1] = 1'b0;
        wait_rsp(ok);
        check("bp_rsp", 32'(ok), 32'd1);
        #1 set_req(3, 8'h0F, 8'h0F);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_product%0d", i), 32'(rsp_product), 32'h0063);
            check($sformatf("bp_id%0d", i), 32'(rsp_id), 32'd1);
            check($sformatf("bp_ready%0d", i), 32'(req_ready), 32'h0);
        end
        #1 rsp_ready = 1'b1;
        tick();
        check("bp_complete", 32'(rsp_valid), 32'd0);
`ifdef MULT_ARB_STATS_EN
        check("bp_stat_stall", 32'(stat_stall), 32'd5);
`endif
        wait_ready(3, ok);
        check("bp_next_grant", 32'(ok), 32'd1);
        tick();
        req_valid[3] = 1'b0;
        wait_rsp(ok);
        check("bp_next_product", 32'(rsp_product), 32'h00E1);
        tick();

        // Reset while in RESP
        rsp_ready = 1'b0;
        set_req(2, 8'h11, 8'h11);
        wait_ready(2, ok);
        tick();
        req_valid[2] = 1'b0;
        wait_rsp(ok);
        check("rr_rsp", 32'(ok), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rr_async_valid", 32'(rsp_valid), 32'd0);
        check("rr_async_ready", 32'(req_ready), 32'h0);
        set_req(0, 8'h02, 8'h03);
        set_req(3, 8'h04, 8'h05);
        tick();
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rr_first_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid[0] = 1'b0;
        wait_rsp(ok);
        check("rr_prod0", 32'(rsp_product), 32'h0006);
        wait_ready(3, ok);
        check("rr_grant3", 32'(ok), 32'd1);
        tick();
        req_valid[3] = 1'b0;
        wait_rsp(ok);
        check("rr_prod3", 32'(rsp_product), 32'h0014);
        tick();

`ifdef MULT_ARB_STATS_EN
        // Wrap of the handshake counter
        tick();
        force dut.stat_ops_reg = 16'hFFFF;
        #1 release dut.stat_ops_reg;
        tick();
        do_op("wrap", 1, 8'h05, 8'h05, 16'h0019);
        check("stat_ops_wrap", 32'(stat_ops), 32'h0);
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
